// File: rtl/mos_dut_sweep_ctrl.sv
// mos_dut_sweep_ctrl: scans a latched DUT mask, settles, converts and streams one result per DUT.
// Define MOS_SWEEP_AVG_EN to convert each DUT four times and report the 4-sample sum.
module mos_dut_sweep_ctrl #(
    parameter int NUM_DUT  = 14,
    parameter int ADC_W    = 10,
    parameter int SETTLE_W = 8
) (
    input  logic                CLK,
    input  logic                RSTB,
    input  logic                START,
    input  logic [NUM_DUT-1:0]  MASK,
    input  logic [SETTLE_W-1:0] SETTLE,
    output logic [NUM_DUT-1:0]  EN_DUT,
    output logic                ADC_START,
    input  logic                ADC_DONE,
    input  logic [ADC_W-1:0]    ADC_DATA,
    output logic                RES_VALID,
    input  logic                RES_READY,
    output logic [3:0]          RES_IDX,
    output logic [ADC_W+1:0]    RES_DATA,
    output logic                BUSY,
    output logic                DONE
);
`ifdef MOS_SWEEP_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_SETTLE, S_CONVERT, S_WAIT, S_OUTPUT, S_FINISH} state_t;
    state_t state, state_n;
    logic [4:0] idx, idx_n;
    logic [NUM_DUT-1:0] mask_q, mask_n, rem, en_n;
    logic [SETTLE_W-1:0] settle_q, settle_n, cnt, cnt_n;
    logic [ADC_W+1:0] acc, acc_n, sample;
    logic [1:0] smp;
    logic adc_start_n, valid_n, done_n, last;
    // rem is empty once no selected DUT remains at or above idx, which ends the sweep early
    assign rem = mask_q >> idx;
    assign last = !AVG || smp == 2'd3;
    assign sample = (AVG ? acc : '0) + {2'b00, ADC_DATA};
    assign RES_IDX = idx[3:0];
    assign RES_DATA = acc;
    always_comb begin
        state_n = state;
        idx_n = idx;
        mask_n = mask_q;
        settle_n = settle_q;
        cnt_n = cnt;
        acc_n = acc;
        en_n = EN_DUT;
        adc_start_n = 1'b0;
        valid_n = RES_VALID;
        done_n = 1'b0;
        case (state)
            S_IDLE: if (START) begin
                state_n = S_SCAN;
                mask_n = MASK;
                settle_n = SETTLE;
                idx_n = '0;
            end
            S_SCAN: begin
                if (rem == '0) begin
                    state_n = S_FINISH;
                    done_n = 1'b1;
                end else if (rem[0]) begin
                    state_n = S_SETTLE;
                    en_n = {{(NUM_DUT-1){1'b0}}, 1'b1} << idx;
                    cnt_n = (settle_q == '0) ? SETTLE_W'(1) : settle_q;
                    acc_n = AVG ? '0 : acc;
                end else idx_n = idx + 5'd1;
            end
            S_SETTLE: begin
                state_n = (cnt == SETTLE_W'(1)) ? S_CONVERT : S_SETTLE;
                adc_start_n = cnt == SETTLE_W'(1);
                cnt_n = cnt - SETTLE_W'(1);
            end
            S_CONVERT: state_n = S_WAIT;
            S_WAIT: if (ADC_DONE) begin
                acc_n = sample;
                state_n = last ? S_OUTPUT : S_CONVERT;
                adc_start_n = !last;
                valid_n = last;
                en_n = last ? '0 : EN_DUT;
            end
            S_OUTPUT: if (RES_READY) begin
                state_n = S_SCAN;
                valid_n = 1'b0;
                idx_n = idx + 5'd1;
            end
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state <= S_IDLE;
            idx <= '0;
            mask_q <= '0;
            settle_q <= '0;
            cnt <= '0;
            acc <= '0;
            smp <= '0;
            EN_DUT <= '0;
            ADC_START <= 1'b0;
            RES_VALID <= 1'b0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            mask_q <= mask_n;
            settle_q <= settle_n;
            cnt <= cnt_n;
            acc <= acc_n;
            smp <= (state == S_SCAN) ? 2'd0 : (state == S_WAIT && ADC_DONE) ? smp + 2'd1 : smp;
            EN_DUT <= en_n;
            ADC_START <= adc_start_n;
            RES_VALID <= valid_n;
            BUSY <= state_n != S_IDLE;
            DONE <= done_n;
        end
    end
endmodule
